// File: rtl/divider_pkg.sv
// rtl/divider_pkg.sv - shared constants, state encoding and sizing helper for the divider
package divider_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } div_state_e;

  // Iteration counter counts WIDTH-1 down to 0.
  function automatic int cnt_width(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

  localparam int DIV_CNT_W = cnt_width(DIV_WIDTH);

endpackage

// File: rtl/full_adder.sv
// rtl/full_adder.sv - single-bit full adder cell of the adder family
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/sub_stage.sv
// rtl/sub_stage.sv - ripple subtractor a + ~b + 1 built from full_adder cells
module sub_stage #(
  parameter int N = 33
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         borrow
);

  logic [N:0] carry;

  assign carry[0] = 1'b1;

  for (genvar i = 0; i < N; i++) begin : g_bit
    full_adder u_fa (
      .a    (a[i]),
      .b    (~b[i]),
      .cin  (carry[i]),
      .sum  (diff[i]),
      .cout (carry[i+1])
    );
  end

  // No carry out of the top bit means a < b.
  assign borrow = ~carry[N];

endmodule

// File: rtl/restoring_divider.sv
// rtl/restoring_divider.sv - multi-cycle unsigned restoring divider, one quotient bit per clock
module restoring_divider
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = cnt_width(WIDTH);

  div_state_e       state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CW-1:0]    count_q, count_d;
  logic             zero_q, zero_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   trial_a;
  logic [WIDTH:0]   trial_diff;
  logic             trial_borrow;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] q_step;

  // Partial remainder shifted left with the next dividend bit brought in.
  assign trial_a = {rem_q, q_q[WIDTH-1]};

  sub_stage #(.N(WIDTH + 1)) u_sub (
    .a      (trial_a),
    .b      ({1'b0, dvs_q}),
    .diff   (trial_diff),
    .borrow (trial_borrow)
  );

  assign rem_step = trial_borrow ? trial_a[WIDTH-1:0] : trial_diff[WIDTH-1:0];
  assign q_step   = {q_q[WIDTH-2:0], ~trial_borrow};

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    q_d         = q_q;
    dvs_d       = dvs_q;
    count_d     = count_q;
    zero_d      = zero_q;
    busy_d      = busy_q;
    done_d      = done_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    case (state_q)
      IDLE, FIN: begin
        done_d  = 1'b0;
        state_d = IDLE;
        if (start) begin
          dvs_d   = divisor;
          zero_d  = (divisor == '0);
          q_d     = dividend;
          rem_d   = '0;
          count_d = (divisor == '0) ? '0 : CW'(WIDTH - 1);
          busy_d  = 1'b1;
          dbz_d   = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (zero_q) begin
          // Divide by zero resolves in a single cycle; q_q still holds the dividend.
          quotient_d  = '1;
          remainder_d = q_q;
          dbz_d       = 1'b1;
          done_d      = 1'b1;
          busy_d      = 1'b0;
          state_d     = FIN;
        end else begin
          rem_d   = rem_step;
          q_d     = q_step;
          count_d = count_q - 1'b1;
          if (count_q == '0) begin
            quotient_d  = q_step;
            remainder_d = rem_step;
            done_d      = 1'b1;
            busy_d      = 1'b0;
            state_d     = FIN;
          end
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      q_q         <= '0;
      dvs_q       <= '0;
      count_q     <= '0;
      zero_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      q_q         <= q_d;
      dvs_q       <= dvs_d;
      count_q     <= count_d;
      zero_q      <= zero_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_restoring_divider.sv
// tb/tb_restoring_divider.sv - vector table, handshake corner cases and random checks for restoring_divider
module tb_restoring_divider;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int tests;
  int fails;

  restoring_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_q;
    logic [W-1:0] exp_r;
    logic         exp_dbz;
    int           exp_lat;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Present operands with start for one edge, then wait (bounded) for done.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = c;
        break;
      end
    end
  endtask

  int lat;
  logic [W-1:0] ra, rb;
  logic [63:0] recon;
  int saw_done;

  initial begin
    tests    = 0;
    fails    = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;

    vecs[0] = '{a: 32'd100,        b: 32'd7, exp_q: 32'd14,         exp_r: 32'd2,          exp_dbz: 1'b0, exp_lat: W};
    vecs[1] = '{a: 32'hFFFF_FFFF,  b: 32'd1, exp_q: 32'hFFFF_FFFF,  exp_r: 32'd0,          exp_dbz: 1'b0, exp_lat: W};
    vecs[2] = '{a: 32'd5,          b: 32'd9, exp_q: 32'd0,          exp_r: 32'd5,          exp_dbz: 1'b0, exp_lat: W};
    vecs[3] = '{a: 32'h1234_5678,  b: 32'd0, exp_q: 32'hFFFF_FFFF,  exp_r: 32'h1234_5678, exp_dbz: 1'b1, exp_lat: 1};
    vecs[4] = '{a: 32'd77,         b: 32'd5, exp_q: 32'd15,         exp_r: 32'd2,          exp_dbz: 1'b0, exp_lat: W};

    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_quotient", 64'(quotient), 64'd0);
    check("reset_remainder", 64'(remainder), 64'd0);
    check("reset_dbz", 64'(div_by_zero), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      launch(vecs[i].a, vecs[i].b);
      check($sformatf("v%0d_busy_after_start", i), 64'(busy), 64'd1);
      if (i == 2) check("v2_quotient_held_during_run", 64'(quotient), 64'hFFFF_FFFF);
      wait_done(lat);
      check($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
      check($sformatf("v%0d_quotient", i), 64'(quotient), 64'(vecs[i].exp_q));
      check($sformatf("v%0d_remainder", i), 64'(remainder), 64'(vecs[i].exp_r));
      check($sformatf("v%0d_dbz", i), 64'(div_by_zero), 64'(vecs[i].exp_dbz));
      check($sformatf("v%0d_busy_at_done", i), 64'(busy), 64'd0);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_done_drops", i), 64'(done), 64'd0);
      check($sformatf("v%0d_result_held", i), 64'(quotient), 64'(vecs[i].exp_q));
    end

    // Start while busy must be ignored, operand changes must not leak in.
    launch(32'd1000, 32'd10);
    repeat (4) @(posedge clk);
    @(negedge clk);
    dividend = 32'd9;
    divisor  = 32'd3;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(lat);
    check("busy_ignore_latency", 64'(lat), 64'(W - 5));
    check("busy_ignore_quotient", 64'(quotient), 64'd100);
    check("busy_ignore_remainder", 64'(remainder), 64'd0);

    // Back-to-back: start raised during the done cycle.
    @(negedge clk);
    dividend = 32'd9;
    divisor  = 32'd3;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("b2b_busy", 64'(busy), 64'd1);
    check("b2b_done_drops", 64'(done), 64'd0);
    check("b2b_quotient_held", 64'(quotient), 64'd100);
    wait_done(lat);
    check("b2b_latency", 64'(lat), 64'(W));
    check("b2b_quotient", 64'(quotient), 64'd3);
    check("b2b_remainder", 64'(remainder), 64'd0);

    // Asynchronous reset in mid-division.
    launch(32'd77, 32'd5);
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_busy", 64'(busy), 64'd0);
    check("midreset_done", 64'(done), 64'd0);
    check("midreset_quotient", 64'(quotient), 64'd0);
    check("midreset_remainder", 64'(remainder), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) saw_done++;
    end
    check("midreset_no_done", 64'(saw_done), 64'd0);
    launch(32'd77, 32'd5);
    wait_done(lat);
    check("after_reset_quotient", 64'(quotient), 64'd15);
    check("after_reset_remainder", 64'(remainder), 64'd2);

    // Random operands against plain / and % plus the division identity.
    for (int n = 0; n < 1000; n++) begin
      ra = $urandom;
      case (n % 4)
        0:       rb = $urandom;
        1:       rb = 32'($urandom_range(1, 255));
        2:       rb = $urandom >> $urandom_range(0, 31);
        default: rb = ra >> $urandom_range(0, 8);
      endcase
      if (rb == '0) rb = 32'd1;
      launch(ra, rb);
      wait_done(lat);
      recon = 64'(quotient) * 64'(rb) + 64'(remainder);
      check($sformatf("rand%0d_quotient %0d/%0d", n, ra, rb), 64'(quotient), 64'(ra / rb));
      check($sformatf("rand%0d_remainder %0d/%0d", n, ra, rb), 64'(remainder), 64'(ra % rb));
      check($sformatf("rand%0d_identity", n), recon, 64'(ra));
      check($sformatf("rand%0d_rem_lt_divisor", n), 64'(remainder < rb), 64'd1);
      if (lat != W) check($sformatf("rand%0d_latency", n), 64'(lat), 64'(W));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/restoring_divider.md
Name: restoring_divider

Overview:
- Multi-cycle unsigned integer divider built on repeated trial subtraction. It is the inverse-direction companion of the team's ripple-carry adder, for the adder/multiplier chip.
- Resolves one quotient bit per clock through a WIDTH+1-bit subtract stage (adder with inverted subtrahend, carry-in 1).
- Uses a start/busy/done handshake so the chip-level controller can sequence it alongside the adders and multipliers.

Parameters:
- WIDTH, 32, operand/quotient/remainder width in bits (minimum 2).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request pulse; sampled only when busy=0.
- dividend  input  WIDTH  unsigned numerator; sampled with start.
- divisor  input  WIDTH  unsigned denominator; sampled with start.
- busy  output  1  high while a division is in progress.
- done  output  1  one-cycle pulse; results valid from this cycle on.
- quotient  output  WIDTH  unsigned quotient; held until next accepted start.
- remainder  output  WIDTH  unsigned remainder; held until next accepted start.
- div_by_zero  output  1  high with done when divisor was 0; held with results.

Behaviour:
- Reset (rst_n=0, async): state=IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0; iteration counter=0. Reset mid-division aborts it; no done is produced.
- States: IDLE, RUN, FIN.
- IDLE:
  - start=1 at edge E0 latches the operands, clears div_by_zero, and sets busy=1.
  - divisor==0: go to FIN.
  - Otherwise: go to RUN with rem=0, q=dividend, count=WIDTH-1.
- RUN, each edge:
  - Shift {rem,q} left by 1.
  - trial = {rem_shifted} - {1'b0,divisor}, computed WIDTH+1 bits wide.
  - No borrow (trial MSB=0): rem=trial[WIDTH-1:0], q[0]=1. Borrow: rem unchanged, q[0]=0.
  - count==0: go to FIN. Else count-1.
- FIN (one cycle, entered at edge E(WIDTH) for normal division):
  - On entering: quotient=q, remainder=rem, done=1, busy=0.
  - Divide-by-zero path enters FIN at E1 with quotient=all ones, remainder=dividend, div_by_zero=1.
  - Next edge: done=0, state=IDLE.
- Latency: normal division is WIDTH cycles from the accepting edge to done high; divide by zero is 1 cycle.
- A start in the FIN cycle is accepted (back-to-back), since busy=0 there. done still drops next cycle and busy rises.
- start while busy=1 is ignored. Operand changes while busy do not affect the result.
- quotient/remainder/div_by_zero only update at FIN entry. In between they hold the previous result, even during a new RUN.
- Invariant for divisor≠0: dividend == quotient*divisor + remainder, with remainder < divisor.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package divider_pkg:
  - DIV_WIDTH default constant (32).
  - State enum {IDLE, RUN, FIN}.
  - Counter width constant $clog2(WIDTH).
- Natural sub-module sub_stage: combinational WIDTH+1-bit subtractor (a + ~b + 1) producing difference and borrow. It is built from the team's full_adder cells, giving a ripple structure consistent with the adder family. Instantiated once in restoring_divider.

Test Plan:
- Reset then dividend=100, divisor=7, start 1 cycle -> busy high for 32 cycles; done pulse 32 cycles after the accepting edge; quotient=14, remainder=2, div_by_zero=0.
- dividend=0xFFFFFFFF, divisor=1 -> quotient=0xFFFFFFFF, remainder=0. Then dividend=5, divisor=9 -> quotient=0, remainder=5.
- dividend=0x12345678, divisor=0 -> done 1 cycle after the accepting edge; quotient=0xFFFFFFFF, remainder=0x12345678, div_by_zero=1.
- Start 1000/10; at cycle 5 pulse start with 9/3 and change the operands -> second start ignored; result quotient=100, remainder=0. Then assert start in the done cycle with 9/3 -> accepted; 32 cycles later quotient=3, remainder=0.
- Start 77/5; drop rst_n at cycle 10 -> busy/done/quotient/remainder=0 immediately; no done pulse after release. A new 77/5 start gives quotient=15, remainder=2.
- 1000 random operand pairs, divisor≠0 -> dividend==quotient*divisor+remainder and remainder<divisor every time.
